// File: rtl/stream_bubble_sorter.sv
// Frame sorter: loads N words, bubble-sorts in place (one compare/swap per cycle), streams them out ascending.
// Latency N(N-1)/2+1 cycles from last input to first output; only one side is open at a time, output holds under !out_ready.
module stream_bubble_sorter #(
  parameter int N = 10,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);
  localparam logic [CW-1:0] IDX_PEN  = CW'(N - 2);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  mem [N];
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] j;
  logic [CW-1:0] pass;
  logic [CW-1:0] rd_cnt;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          busy_q;

  logic [CW-1:0] j_nxt;
  logic          swap;
  logic          pass_end;

  assign j_nxt    = j + ONE;
  assign swap     = mem[j] > mem[j_nxt];
  // Each pass ends one slot earlier because the largest remaining word has bubbled to the top.
  assign pass_end = (j + pass) == IDX_PEN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      wr_cnt      <= '0;
      j           <= '0;
      pass        <= '0;
      rd_cnt      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready_q) begin
            mem[wr_cnt] <= in_data;
            if (wr_cnt == IDX_LAST) begin
              wr_cnt     <= '0;
              j          <= '0;
              pass       <= '0;
              state      <= SORT;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + ONE;
            end
          end
        end
        SORT: begin
          if (swap) begin
            mem[j]     <= mem[j_nxt];
            mem[j_nxt] <= mem[j];
          end
          if (pass_end) begin
            j    <= '0;
            pass <= pass + ONE;
            if (pass == IDX_PEN) begin
              pass        <= '0;
              rd_cnt      <= '0;
              state       <= DRAIN;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
            end
          end else begin
            j <= j_nxt;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last_q) begin
              state       <= LOAD;
              rd_cnt      <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              rd_cnt     <= rd_cnt + ONE;
              out_last_q <= (rd_cnt == IDX_PEN);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_valid_q ? mem[rd_cnt] : '0;

endmodule

// File: tb/tb_stream_bubble_sorter.sv
// Directed bench for stream_bubble_sorter: reset, ordering, latency, backpressure, ignored input, mid-sort reset.
module tb_stream_bubble_sorter;
  localparam int N = 10;
  localparam int W = 32;
  localparam int SORT_LAT = 46;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  stream_bubble_sorter #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one frame; hs is the cycle of the final input handshake. hold keeps in_valid high with AAAAAAAA afterwards.
  task automatic load_frame(input logic [W-1:0] v [N], input bit gaps, input bit hold, output int hs);
    int k;
    int guard;
    bit tog;
    k = 0; guard = 0; tog = 1'b0; hs = -1;
    while (k < N && guard < 200) begin
      @(negedge clk);
      guard++;
      if (gaps && tog) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = v[k];
      end
      tog = ~tog;
      if (in_valid && in_ready) begin
        hs = cyc;
        k++;
      end
    end
    if (k < N) begin
      checks++; errors++;
      $display("FAIL load_timeout: accepted %0d words, required %0d", k, N);
    end
    @(negedge clk);
    in_valid = hold;
    in_data  = 32'hAAAAAAAA;
  endtask

  task automatic drain_fast(output logic [W-1:0] d [N], output logic l [N], output int t [N],
                            output int inrdy_hi);
    int k;
    int guard;
    k = 0; guard = 0; inrdy_hi = 0;
    for (int i = 0; i < N; i++) begin d[i] = 'x; l[i] = 1'bx; t[i] = -1; end
    out_ready = 1'b1;
    while (k < N && guard < 300) begin
      @(negedge clk);
      guard++;
      if (in_ready) inrdy_hi++;
      if (out_valid) begin
        d[k] = out_data;
        l[k] = out_last;
        t[k] = cyc;
        k++;
      end
    end
    if (k < N) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d words, required %0d", k, N);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_held: busy=%b in_ready=%b, required 0/1", busy, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: %b, required 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: %b, required 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: %b, required 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: %h, required 0", out_data); end
  endtask

  task automatic test_reverse();
    logic [W-1:0] v [N];
    logic [W-1:0] d [N];
    logic l [N];
    int t [N];
    int hs, ih;
    for (int i = 0; i < N; i++) v[i] = W'(N - 1 - i);
    load_frame(v, 1'b0, 1'b0, hs);
    drain_fast(d, l, t, ih);
    checks++;
    if (t[0] - hs !== SORT_LAT) begin
      errors++; $display("FAIL rev_latency: %0d cycles, required %0d", t[0] - hs, SORT_LAT);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (d[i] !== W'(i)) begin errors++; $display("FAIL rev_data[%0d]: %h, required %h", i, d[i], W'(i)); end
      checks++;
      if (l[i] !== (i == N - 1)) begin errors++; $display("FAIL rev_last[%0d]: %b, required %b", i, l[i], i == N - 1); end
      if (i > 0) begin
        checks++;
        if (t[i] !== t[0] + i) begin errors++; $display("FAIL rev_consecutive[%0d]: cycle %0d, required %0d", i, t[i], t[0] + i); end
      end
    end
    checks++;
    if (ih !== 0) begin errors++; $display("FAIL rev_in_ready_busy: high %0d cycles, required 0", ih); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rev_in_ready_after: %b, required 1", in_ready); end
  endtask

  task automatic test_extremes();
    logic [W-1:0] v [N];
    logic [W-1:0] e [N];
    logic [W-1:0] d [N];
    logic l [N];
    int t [N];
    int hs, ih;
    v = '{32'hFFFFFFFF, 32'h0, 32'h5, 32'h80000000, 32'h5, 32'h1, 32'h7FFFFFFF, 32'h0, 32'h2, 32'h3};
    e = '{32'h0, 32'h0, 32'h1, 32'h2, 32'h3, 32'h5, 32'h5, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    load_frame(v, 1'b0, 1'b0, hs);
    drain_fast(d, l, t, ih);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (d[i] !== e[i]) begin errors++; $display("FAIL ext_data[%0d]: %h, required %h", i, d[i], e[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] v [N];
    logic [W-1:0] e [N];
    bit pat [6];
    logic [W-1:0] pd;
    logic pl;
    bit stalled;
    int k, i, guard, hs;
    v = '{32'd40, 32'd10, 32'd90, 32'd20, 32'd70, 32'd30, 32'd60, 32'd50, 32'd80, 32'd0};
    e = '{32'd0, 32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80, 32'd90};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b0;
    load_frame(v, 1'b0, 1'b0, hs);
    k = 0; i = 0; guard = 0; stalled = 1'b0; pd = '0; pl = 1'b0;
    while (k < N && guard < 400) begin
      @(negedge clk);
      guard++;
      if (out_valid) begin
        if (stalled) begin
          checks++;
          if (out_data !== pd || out_last !== pl) begin
            errors++; $display("FAIL bp_stable: %h/%b, required %h/%b", out_data, out_last, pd, pl);
          end
        end
        out_ready = pat[i % 6];
        i++;
        if (out_ready) begin
          checks++;
          if (out_data !== e[k] || out_last !== (k == N - 1)) begin
            errors++; $display("FAIL bp_word[%0d]: %h/%b, required %h/%b", k, out_data, out_last, e[k], k == N - 1);
          end
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd = out_data;
          pl = out_last;
        end
      end else out_ready = 1'b0;
    end
    if (k < N) begin
      checks++; errors++; $display("FAIL bp_timeout: got %0d words, required %0d", k, N);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_after: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_gaps_ignored();
    logic [W-1:0] v [N];
    logic [W-1:0] e [N];
    logic [W-1:0] d [N];
    logic l [N];
    int t [N];
    int hs, ih, seen;
    v = '{32'd12, 32'd3, 32'd40, 32'd3, 32'd7, 32'd0, 32'd100, 32'd55, 32'd1, 32'd2};
    e = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd3, 32'd7, 32'd12, 32'd40, 32'd55, 32'd100};
    load_frame(v, 1'b1, 1'b1, hs);
    drain_fast(d, l, t, ih);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (ih !== 0) begin errors++; $display("FAIL gap_in_ready_busy: high %0d cycles, required 0", ih); end
    seen = 0;
    for (int i = 0; i < N; i++) begin
      if (d[i] === 32'hAAAAAAAA) seen++;
      checks++;
      if (d[i] !== e[i]) begin errors++; $display("FAIL gap_data[%0d]: %h, required %h", i, d[i], e[i]); end
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL gap_aaaa_seen: %0d times, required 0", seen); end
    checks++;
    if (t[0] - hs !== SORT_LAT) begin errors++; $display("FAIL gap_latency: %0d, required %0d", t[0] - hs, SORT_LAT); end
  endtask

  task automatic test_reset_mid_sort();
    logic [W-1:0] a [N];
    logic [W-1:0] v [N];
    logic [W-1:0] d [N];
    logic l [N];
    int t [N];
    int hs, ih;
    for (int i = 0; i < N; i++) a[i] = 32'hDEAD0000 + W'(N - i);
    load_frame(a, 1'b0, 1'b0, hs);
    repeat (19) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_busy: busy=%b in_ready=%b, required 1/0", busy, in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_async: busy=%b in_ready=%b out_valid=%b, required 0/1/0", busy, in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = '{32'd3, 32'd1, 32'd2, 32'd0, 32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4};
    load_frame(v, 1'b0, 1'b0, hs);
    drain_fast(d, l, t, ih);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (d[i] !== W'(i)) begin errors++; $display("FAIL mid_data[%0d]: %h, required %h", i, d[i], W'(i)); end
    end
    checks++;
    if (t[0] - hs !== SORT_LAT) begin errors++; $display("FAIL mid_latency: %0d, required %0d", t[0] - hs, SORT_LAT); end
    for (int i = 0; i < N; i++) v[i] = W'(2 * (N - i));
    load_frame(v, 1'b0, 1'b0, hs);
    drain_fast(d, l, t, ih);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (d[i] !== W'(2 * (i + 1))) begin errors++; $display("FAIL b2b_data[%0d]: %h, required %h", i, d[i], W'(2 * (i + 1))); end
    end
    checks++;
    if (t[0] - hs !== SORT_LAT) begin errors++; $display("FAIL b2b_latency: %0d, required %0d", t[0] - hs, SORT_LAT); end
    checks++;
    if (l[N-1] !== 1'b1 || l[0] !== 1'b0) begin errors++; $display("FAIL b2b_last: first=%b final=%b, required 0/1", l[0], l[N-1]); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reverse();
    test_extremes();
    test_backpressure();
    test_gaps_ignored();
    test_reset_mid_sort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
